// File: rtl/module_divisor_seq.sv
// Sequential restoring divider: one quotient bit per clock through an IDLE/CALC/DONE FSM.
// Optional macro DIV_EARLY_EXIT_EN finishes at once when the dividend is below a nonzero divisor.
module module_divisor_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [1:0]       state_dbg_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] dvd_sh;
    logic             early;

    // Handshake: start is a request sampled on every rising edge; it is accepted
    // only in IDLE or DONE, ignored while busy, and done pulses once per result.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        rem_sh  = '0;
        dvd_sh  = '0;
`ifdef DIV_EARLY_EXIT_EN
        early   = (A < B);
`else
        early   = 1'b0;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    dvd_d = A;
                    dsr_d = B;
                    rem_d = '0;
                    cnt_d = CW'(WIDTH);
                    if (B == '0) begin
                        state_d = S_DONE;
                        q_d     = '1;
                        r_d     = A;
                        dz_d    = 1'b1;
                    end else if (early) begin
                        state_d = S_DONE;
                        q_d     = '0;
                        r_d     = A;
                        dz_d    = 1'b0;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                // Remainder is one bit wider than B so compare/subtract cannot wrap.
                rem_sh = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
                dvd_sh = dvd_q << 1;
                if (rem_sh >= {1'b0, dsr_q}) begin
                    rem_sh    = rem_sh - {1'b0, dsr_q};
                    dvd_sh[0] = 1'b1;
                end
                rem_d = rem_sh;
                dvd_d = dvd_sh;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    q_d     = dvd_sh;
                    r_d     = rem_sh[WIDTH-1:0];
                    dz_d    = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign Q           = q_q;
    assign R           = r_q;
    assign div_zero    = dz_q;
    assign busy        = (state_q == S_CALC);
    assign done        = (state_q == S_DONE);
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_module_divisor_seq.sv
// Bench for module_divisor_seq: directed scenarios plus random operands against an arithmetic model.
module tb_module_divisor_seq;
  localparam int W  = 4;
  localparam int RW = 2 * W + 1;
  localparam int MAX_WAIT = 50;

  logic         clk;
  logic         rst_in;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [W-1:0] q_out;
  logic [W-1:0] r_out;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [1:0]   state_dbg;

  int checks = 0;
  int errors = 0;
  logic [RW-1:0] exp_q[$];

  module_divisor_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_in     (rst_in),
    .start      (start),
    .A          (a_in),
    .B          (b_in),
    .Q          (q_out),
    .R          (r_out),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .state_dbg_o(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: {div_zero, R, Q}
  function automatic logic [RW-1:0] model(input int a, input int b);
    int q, r;
    if (b == 0) begin
      q = (1 << W) - 1;
      r = a;
      return {1'b1, r[W-1:0], q[W-1:0]};
    end
    q = a / b;
    r = a % b;
    return {1'b0, r[W-1:0], q[W-1:0]};
  endfunction

  function automatic int exp_lat(input int a, input int b);
    if (b == 0) return 1;
`ifdef DIV_EARLY_EXIT_EN
    if (a < b) return 1;
`endif
    return W + 1;
  endfunction

  // driver: one start pulse, then wait for done; returns observations
  task automatic do_div(input int a, input int b, output int lat, output logic [RW-1:0] res,
                        output int busy_cyc, output bit held_ok, output bit single_done);
    logic [RW-1:0] prev;
    prev     = {div_zero, r_out, q_out};
    start    = 1'b1;
    a_in     = a[W-1:0];
    b_in     = b[W-1:0];
    @(posedge clk); #1;
    start    = 1'b0;
    a_in     = W'($urandom);
    b_in     = W'($urandom);
    lat      = 1;
    busy_cyc = 0;
    held_ok  = 1'b1;
    while (!done && lat < MAX_WAIT) begin
      if (busy) busy_cyc++;
      if ({div_zero, r_out, q_out} !== prev) held_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    res = {div_zero, r_out, q_out};
    @(posedge clk); #1;
    single_done = !done;
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    start  = 1'b0;
    a_in   = '0;
    b_in   = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({q_out, r_out} !== '0) begin
      errors++;
      $display("FAIL reset_qr: got Q=%0d R=%0d, want 0 0", q_out, r_out);
    end
    checks++;
    if ({busy, done, div_zero} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got busy=%b done=%b dz=%b, want 0 0 0", busy, done, div_zero);
    end
    rst_in = 1'b1;
  endtask

  task automatic test_directed();
    int ta[6] = '{13, 15, 0, 9, 8, 2};
    int tb[6] = '{4, 1, 5, 0, 2, 7};
    int lat, bc;
    bit held, single;
    logic [RW-1:0] res, exp;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(model(ta[i], tb[i]));
      do_div(ta[i], tb[i], lat, res, bc, held, single);
      exp = exp_q.pop_front();
      checks++;
      if (lat !== exp_lat(ta[i], tb[i])) begin
        errors++;
        $display("FAIL dir_latency %0d/%0d: got %0d, want %0d", ta[i], tb[i], lat, exp_lat(ta[i], tb[i]));
      end
      checks++;
      if (res !== exp) begin
        errors++;
        $display("FAIL dir_result %0d/%0d: got dz,R,Q=%h, want %h", ta[i], tb[i], res, exp);
      end
      checks++;
      if (bc !== exp_lat(ta[i], tb[i]) - 1) begin
        errors++;
        $display("FAIL dir_busy %0d/%0d: got %0d busy cycles, want %0d", ta[i], tb[i], bc, exp_lat(ta[i], tb[i]) - 1);
      end
      checks++;
      if (!held || !single) begin
        errors++;
        $display("FAIL dir_hold_pulse %0d/%0d: got held=%0b single_done=%0b, want 1 1", ta[i], tb[i], held, single);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    // 14/3 accepted; a second start two cycles later must be ignored
    start = 1'b1; a_in = 4'd14; b_in = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    @(posedge clk); #1;
    cyc++;
    start = 1'b1; a_in = 4'd5; b_in = 4'd5;
    @(posedge clk); #1;
    cyc++;
    start = 1'b0;
    while (!done && cyc < MAX_WAIT) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc !== W + 1) begin
      errors++;
      $display("FAIL b2b_first_latency: got %0d, want %0d", cyc, W + 1);
    end
    checks++;
    if ({div_zero, r_out, q_out} !== model(14, 3)) begin
      errors++;
      $display("FAIL b2b_first_result: got Q=%0d R=%0d dz=%b, want Q=4 R=2 dz=0", q_out, r_out, div_zero);
    end
    // start presented in the DONE cycle is accepted
    start = 1'b1; a_in = 4'd5; b_in = 4'd5;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < MAX_WAIT) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc !== exp_lat(5, 5)) begin
      errors++;
      $display("FAIL b2b_second_latency: got %0d, want %0d", cyc, exp_lat(5, 5));
    end
    checks++;
    if ({div_zero, r_out, q_out} !== model(5, 5)) begin
      errors++;
      $display("FAIL b2b_second_result: got Q=%0d R=%0d dz=%b, want Q=1 R=0 dz=0", q_out, r_out, div_zero);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_calc();
    bit seen_done;
    int lat, bc;
    bit held, single;
    logic [RW-1:0] res;
    start = 1'b1; a_in = 4'd14; b_in = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_in = 1'b0;
    #1;
    checks++;
    if ({q_out, r_out, busy, done, div_zero} !== '0) begin
      errors++;
      $display("FAIL midreset_async: got Q=%0d R=%0d busy=%b done=%b dz=%b, want all 0",
               q_out, r_out, busy, done, div_zero);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_in = 1'b1;
    seen_done = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    checks++;
    if (seen_done) begin
      errors++;
      $display("FAIL midreset_no_done: got done pulse after abort, want none");
    end
    exp_q.push_back(model(7, 2));
    do_div(7, 2, lat, res, bc, held, single);
    checks++;
    if (lat !== W + 1) begin
      errors++;
      $display("FAIL midreset_after_latency: got %0d, want %0d", lat, W + 1);
    end
    checks++;
    if (res !== exp_q.pop_front()) begin
      errors++;
      $display("FAIL midreset_after_result: got Q=%0d R=%0d, want Q=3 R=1", res[W-1:0], res[2*W-1:W]);
    end
  endtask

  task automatic test_random();
    int a, b, lat, bc;
    bit held, single;
    logic [RW-1:0] res, exp;
    for (int n = 0; n < 40; n++) begin
      a = $urandom_range(0, (1 << W) - 1);
      b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, (1 << W) - 1);
      exp_q.push_back(model(a, b));
      do_div(a, b, lat, res, bc, held, single);
      exp = exp_q.pop_front();
      checks++;
      if (res !== exp) begin
        errors++;
        $display("FAIL rand_result %0d/%0d: got dz,R,Q=%h, want %h", a, b, res, exp);
      end
      checks++;
      if (lat !== exp_lat(a, b) || bc !== exp_lat(a, b) - 1) begin
        errors++;
        $display("FAIL rand_timing %0d/%0d: got lat=%0d busy=%0d, want %0d %0d",
                 a, b, lat, bc, exp_lat(a, b), exp_lat(a, b) - 1);
      end
      checks++;
      if (!held || !single) begin
        errors++;
        $display("FAIL rand_hold_pulse %0d/%0d: got held=%0b single_done=%0b, want 1 1", a, b, held, single);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_calc();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/module_divisor_seq.md
MODULE_DIVISOR_SEQ -- requirements
Module: module_divisor_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand and result width in bits.
REQ-002 Port clk, input, 1 bit: single clock; all state SHALL change on its rising edge.
REQ-003 Port rst_in, input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port start, input, 1 bit: request to begin a division, sampled on the rising edge of clk.
REQ-005 Port A, input, WIDTH bits: unsigned dividend, sampled when start is accepted.
REQ-006 Port B, input, WIDTH bits: unsigned divisor, sampled when start is accepted.
REQ-007 Port Q, output, WIDTH bits: registered quotient of the last completed division.
REQ-008 Port R, output, WIDTH bits: registered remainder of the last completed division.
REQ-009 Port busy, output, 1 bit: high while a division is in progress.
REQ-010 Port done, output, 1 bit: single-cycle pulse marking the cycle in which Q and R become valid.
REQ-011 Port div_zero, output, 1 bit: registered flag, high when the last completed division had B=0.

Function
REQ-012 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-013 In IDLE or DONE, start=1 SHALL be accepted: latch A and B, clear the partial remainder, load the iteration counter with WIDTH, and go to CALC.
REQ-014 In CALC, each cycle SHALL perform one restoring step: shift {rem, dividend} left by 1; if rem >= B then rem = rem - B and set quotient LSB = 1; then decrement the counter.
REQ-015 The partial remainder SHALL be WIDTH+1 bits internally so that the compare and subtract never overflow.
REQ-016 When the counter reaches 0 after the last step, the FSM SHALL go to DONE; Q, R and div_zero SHALL update on that same edge.
REQ-017 done SHALL be high only in DONE and SHALL stay high for exactly one cycle; the FSM SHALL return to IDLE unless start=1.
REQ-018 Latency for B!=0 SHALL be WIDTH+1 cycles from the start-sampling edge to the done-high cycle.
REQ-019 busy SHALL be 1 exactly while in CALC.
REQ-020 start while busy=1 SHALL be ignored, with no effect on the operation in progress.
REQ-021 If B=0 at acceptance, the block SHALL skip CALC and enter DONE on the next edge, giving latency 1, Q = all ones, R = A and div_zero = 1.
REQ-022 div_zero SHALL be 0 for every completed division with B!=0.
REQ-023 Q, R and div_zero SHALL hold their values until the next done; they SHALL NOT change during CALC.
REQ-024 A and B changing after acceptance SHALL NOT affect the result.

Reset
REQ-025 rst_in=0 SHALL immediately force IDLE, Q=0, R=0, busy=0, done=0, div_zero=0, and clear all internal registers.
REQ-026 Reset asserted mid-CALC SHALL abort the division without producing a done pulse.
REQ-027 After rst_in returns to 1, the first start SHALL be accepted on the next rising edge.

Configuration
REQ-028 When macro DIV_EARLY_EXIT_EN is defined, a start with B!=0 and A<B SHALL skip CALC and reach DONE on the next edge (latency 1), with Q=0 and R=A.
REQ-029 When DIV_EARLY_EXIT_EN is undefined, A<B SHALL take the full WIDTH+1 latency and produce the same Q=0, R=A result.

Verification (WIDTH=4)
REQ-030 A=13, B=4, 1-cycle start -> busy high for 4 cycles; done at start edge +5; Q=3, R=1, div_zero=0.
REQ-031 A=15, B=1 -> Q=15, R=0; A=0, B=5 -> Q=0, R=0; each with done exactly one cycle wide.
REQ-032 A=9, B=0 -> done at start edge +1; Q=15, R=9, div_zero=1; a following A=8, B=2 -> Q=4, R=0, div_zero=0.
REQ-033 A=2, B=7 -> Q=0, R=2; done at +1 with DIV_EARLY_EXIT_EN defined, at +5 without it.
REQ-034 A=14, B=3 started; A=5, B=5 presented with start=1 two cycles later -> the second start is ignored; Q=4, R=2 at +5; then a start accepted in the DONE cycle with A=5, B=5 -> Q=1, R=0.
REQ-035 rst_in driven low 2 cycles into CALC -> outputs read 0 asynchronously and no done pulse occurs; after release, A=7, B=2 -> Q=3, R=1.
